// File: rtl/gamma_sequencer.sv
// Gamma-cycle sequencer for one race-logic operator: latches a request of spike
// times, plays them as width-P pulses for one gamma cycle, and returns the first op_y time.
module gamma_sequencer #(
  parameter int N_IN              = 2,
  parameter int GAMMA_CYCLE_WIDTH = 16,
  parameter int PULSE_WIDTH       = 8,
  parameter int TW                = $clog2(GAMMA_CYCLE_WIDTH)
) (
  input  logic              aclk,
  input  logic              grst,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [N_IN*TW-1:0] start_times,
  input  logic [N_IN-1:0]   start_mask,
  input  logic              abort,
  output logic [N_IN-1:0]   spk_out,
  output logic              op_rst,
  input  logic              op_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [TW-1:0]     res_time,
  output logic              res_spike,
  output logic              busy
);

  // Wide enough that time + P never overflows for any legal time.
  localparam int CW = TW + 2;
  localparam logic [CW-1:0] G_C    = CW'(GAMMA_CYCLE_WIDTH);
  localparam logic [CW-1:0] P_C    = CW'(PULSE_WIDTH);
  localparam logic [TW-1:0] LAST_T = TW'(GAMMA_CYCLE_WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [TW-1:0]       t, t_next;
  logic [N_IN*TW-1:0]  times_q;
  logic [N_IN-1:0]     mask_q;
  logic [N_IN-1:0]     spk_calc;
  logic                cap;
  logic [TW-1:0]       cap_time;
  logic [TW-1:0]       tm_sel [N_IN];
  logic [N_IN-1:0]     en_sel;

  always_ff @(posedge aclk or posedge grst) begin
    if (grst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    start_ready = 1'b0;
    op_rst      = 1'b1;
    busy        = 1'b0;
    res_valid   = 1'b0;
    case (state)
      IDLE: begin
        start_ready = 1'b1;
        if (start_valid) state_nxt = RUN;
      end
      RUN: begin
        op_rst = 1'b0;
        busy   = 1'b1;
        if (abort)            state_nxt = IDLE;
        else if (t == LAST_T) state_nxt = DONE;
      end
      DONE: begin
        res_valid = 1'b1;
        if (res_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // spk_out is registered, so its next value is evaluated for the cycle about to start.
  always_comb begin
    t_next = (state == IDLE) ? '0 : t + 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      tm_sel[i] = (state == IDLE) ? start_times[i*TW +: TW] : times_q[i*TW +: TW];
      en_sel[i] = (state == IDLE) ? (start_mask[i] && (CW'(tm_sel[i]) < G_C)) : mask_q[i];
      spk_calc[i] = en_sel[i] && (CW'(t_next) >= CW'(tm_sel[i]))
                    && (CW'(t_next) < CW'(tm_sel[i]) + P_C);
    end
  end

  // NOTE: all state below updates with non-blocking assignments so every flop
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge aclk or posedge grst) begin
    if (grst) begin
      t         <= '0;
      times_q   <= '0;
      mask_q    <= '0;
      spk_out   <= '0;
      cap       <= 1'b0;
      cap_time  <= '0;
      res_time  <= '0;
      res_spike <= 1'b0;
    end else begin
      spk_out <= (state_nxt == RUN) ? spk_calc : '0;
      case (state)
        IDLE: if (start_valid) begin
          t       <= '0;
          cap     <= 1'b0;
          times_q <= start_times;
          mask_q  <= en_sel;
        end
        RUN: begin
          t <= t + 1'b1;
          if (op_y && !cap) begin
            cap      <= 1'b1;
            cap_time <= t;
          end
          // Results are published only when a run completes, so an abort leaves them untouched.
          if (t == LAST_T && !abort) begin
            res_spike <= cap | op_y;
            res_time  <= cap ? cap_time : LAST_T;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_gamma_sequencer.sv
// Self-checking bench for gamma_sequencer: directed table, reset/abort corners,
// and randomized requests checked against a spike-time reference model.
module tb_gamma_sequencer;
  localparam int N_IN = 2;
  localparam int G    = 16;
  localparam int P    = 8;
  localparam int TW   = $clog2(G);

  logic              aclk = 1'b0;
  logic              grst;
  logic              start_valid;
  logic              start_ready;
  logic [N_IN*TW-1:0] start_times;
  logic [N_IN-1:0]   start_mask;
  logic              abort;
  logic [N_IN-1:0]   spk_out;
  logic              op_rst;
  logic              op_y;
  logic              res_valid;
  logic              res_ready;
  logic [TW-1:0]     res_time;
  logic              res_spike;
  logic              busy;

  gamma_sequencer #(.N_IN(N_IN), .GAMMA_CYCLE_WIDTH(G), .PULSE_WIDTH(P)) dut (
    .aclk(aclk), .grst(grst),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_times(start_times), .start_mask(start_mask),
    .abort(abort), .spk_out(spk_out), .op_rst(op_rst), .op_y(op_y),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_time(res_time), .res_spike(res_spike), .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_checks = 0;
  int n_fail   = 0;
  int last_time  = 0;
  int last_spike = 0;

  typedef struct {
    int          ta;
    int          tb;
    logic [1:0]  mask;
    logic [G-1:0] ypat;
    int          abort_at;
    int          rdly;
    int          exp_time;
    int          exp_spike;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // A spike at time tm occupies [tm, tm+P), cut off at the end of the gamma cycle.
  function automatic logic model_spk(int tm, logic m, int t);
    return m && (tm < G) && (t >= tm) && (t < tm + P) && (t < G);
  endfunction

  function automatic int model_first(logic [G-1:0] yp);
    for (int k = 0; k < G; k++) if (yp[k]) return k;
    return -1;
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
  task automatic run_req(input string nm, input vec_t v);
    bit aborted = 0;
    check({nm, "_start_ready"}, start_ready, 1);
    start_valid = 1'b1;
    start_times = {TW'(v.tb), TW'(v.ta)};
    start_mask  = v.mask;
    @(negedge aclk);
    start_valid = 1'b0;
    for (int k = 0; k < G; k++) begin
      check({nm, "_spk"}, spk_out, {model_spk(v.tb, v.mask[1], k), model_spk(v.ta, v.mask[0], k)});
      check({nm, "_op_rst"}, op_rst, 0);
      check({nm, "_busy"}, busy, 1);
      check({nm, "_res_valid_run"}, res_valid, 0);
      op_y  = v.ypat[k];
      abort = (k == v.abort_at);
      @(negedge aclk);
      if (abort) begin
        aborted = 1;
        break;
      end
    end
    op_y  = 1'b0;
    abort = 1'b0;
    if (aborted) begin
      check({nm, "_abort_idle"}, start_ready, 1);
      check({nm, "_abort_op_rst"}, op_rst, 1);
      check({nm, "_abort_spk"}, spk_out, 0);
      check({nm, "_abort_res_valid"}, res_valid, 0);
      check({nm, "_abort_res_time"}, res_time, last_time);
      check({nm, "_abort_res_spike"}, res_spike, last_spike);
      return;
    end
    check({nm, "_res_valid"}, res_valid, 1);
    check({nm, "_res_time"}, res_time, v.exp_time);
    check({nm, "_res_spike"}, res_spike, v.exp_spike);
    check({nm, "_done_spk"}, spk_out, 0);
    check({nm, "_done_op_rst"}, op_rst, 1);
    for (int d = 0; d < v.rdly; d++) begin
      start_valid = 1'b1;
      @(negedge aclk);
      check({nm, "_hold_valid"}, res_valid, 1);
      check({nm, "_hold_time"}, res_time, v.exp_time);
      check({nm, "_hold_spike"}, res_spike, v.exp_spike);
      check({nm, "_hold_start_ready"}, start_ready, 0);
      check({nm, "_hold_busy"}, busy, 0);
    end
    start_valid = 1'b0;
    res_ready   = 1'b1;
    @(negedge aclk);
    res_ready = 1'b0;
    check({nm, "_after_valid"}, res_valid, 0);
    check({nm, "_after_ready"}, start_ready, 1);
    last_time  = v.exp_time;
    last_spike = v.exp_spike;
  endtask

  vec_t tbl [7];

  initial begin
    vec_t rv;
    int   f;
    tbl[0] = '{ta: 2,  tb: 4,  mask: 2'b11, ypat: 16'hFFF0, abort_at: -1, rdly: 0, exp_time: 4,  exp_spike: 1};
    tbl[1] = '{ta: 0,  tb: 0,  mask: 2'b00, ypat: 16'h0000, abort_at: -1, rdly: 0, exp_time: 15, exp_spike: 0};
    tbl[2] = '{ta: 12, tb: 0,  mask: 2'b11, ypat: 16'h0201, abort_at: -1, rdly: 0, exp_time: 0,  exp_spike: 1};
    tbl[3] = '{ta: 5,  tb: 5,  mask: 2'b11, ypat: 16'h0100, abort_at: -1, rdly: 5, exp_time: 8,  exp_spike: 1};
    tbl[4] = '{ta: 3,  tb: 7,  mask: 2'b11, ypat: 16'h0004, abort_at: 5,  rdly: 0, exp_time: 0,  exp_spike: 0};
    tbl[5] = '{ta: 1,  tb: 3,  mask: 2'b01, ypat: 16'h8000, abort_at: -1, rdly: 1, exp_time: 15, exp_spike: 1};
    tbl[6] = '{ta: 15, tb: 9,  mask: 2'b10, ypat: 16'h0C00, abort_at: 15, rdly: 0, exp_time: 0,  exp_spike: 0};

    grst = 1'b1; start_valid = 1'b0; start_times = '0; start_mask = '0;
    abort = 1'b0; op_y = 1'b0; res_ready = 1'b0;
    #1;
    check("rst_start_ready", start_ready, 1);
    check("rst_op_rst", op_rst, 1);
    check("rst_spk", spk_out, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_time", res_time, 0);
    check("rst_res_spike", res_spike, 0);
    check("rst_busy", busy, 0);
    repeat (2) @(negedge aclk);
    grst = 1'b0;
    @(negedge aclk);

    for (int i = 0; i < 7; i++) run_req($sformatf("tbl%0d", i), tbl[i]);

    // Asynchronous reset in the middle of a run.
    start_valid = 1'b1; start_times = {TW'(4), TW'(2)}; start_mask = 2'b11;
    @(negedge aclk);
    start_valid = 1'b0;
    repeat (7) @(negedge aclk);
    check("grst_pre_busy", busy, 1);
    #2 grst = 1'b1;
    #1;
    check("grst_spk", spk_out, 0);
    check("grst_op_rst", op_rst, 1);
    check("grst_start_ready", start_ready, 1);
    check("grst_busy", busy, 0);
    check("grst_res_valid", res_valid, 0);
    check("grst_res_time", res_time, 0);
    check("grst_res_spike", res_spike, 0);
    @(negedge aclk);
    grst = 1'b0;
    last_time = 0; last_spike = 0;
    for (int k = 0; k < G + 2; k++) begin
      @(negedge aclk);
      check("grst_no_result", res_valid, 0);
    end
    run_req("post_grst", tbl[0]);

    // Randomized requests against the reference model.
    for (int r = 0; r < 40; r++) begin
      rv.ta   = int'($urandom_range(0, G - 1));
      rv.tb   = ($urandom_range(0, 3) == 0) ? rv.ta : int'($urandom_range(0, G - 1));
      rv.mask = 2'($urandom);
      rv.ypat = '0;
      if ($urandom_range(0, 4) != 0) begin
        f = int'($urandom_range(0, G - 1));
        for (int k = f; k < G; k++) rv.ypat[k] = 1'($urandom);
        rv.ypat[f] = 1'b1;
      end
      rv.abort_at = ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, G - 1)) : -1;
      rv.rdly     = int'($urandom_range(0, 3));
      f = model_first(rv.ypat);
      rv.exp_spike = (f >= 0) ? 1 : 0;
      rv.exp_time  = (f >= 0) ? f : G - 1;
      run_req($sformatf("rnd%0d", r), rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/gamma_sequencer.md
Name: gamma_sequencer

Overview:
- Sequences one temporal (race-logic) operator through gamma cycles.
- Accepts a request holding N_IN spike times. Holds the operator in reset between requests.
- During the run phase, drives pulse-width-encoded input spikes. Time-stamps the first rising of the operator output and returns that time over a valid/ready handshake.
- Sits between the binary-domain scheduler and one temporal operator (equal, min, max, inhibit, ...).

Parameters:
- N_IN, 2, number of operator input lines.
- GAMMA_CYCLE_WIDTH, 16, aclk cycles per gamma cycle (G); must be >= 2.
- PULSE_WIDTH, 8, spike pulse length in aclk cycles (P); 1 <= P <= G.
- TW, $clog2(GAMMA_CYCLE_WIDTH), width of one time value.

Ports:
- aclk  input  1  clock; all state changes on rising edge.
- grst  input  1  asynchronous, active-high reset.
- start_valid  input  1  request valid.
- start_ready  output  1  request ready.
- start_times  input  N_IN*TW  spike time per input; input i uses bits [i*TW +: TW].
- start_mask  input  N_IN  1 = input i spikes; 0 = no spike (infinity).
- abort  input  1  synchronous cancel of the current run.
- spk_out  output  N_IN  pulse-width spike lines to the operator.
- op_rst  output  1  operator reset.
- op_y  input  1  operator output.
- res_valid  output  1  result valid.
- res_ready  input  1  result ready.
- res_time  output  TW  time of first op_y high.
- res_spike  output  1  1 = op_y rose during the run.
- busy  output  1  high in RUN.

Behaviour:
- Reset (grst=1, asynchronous): state=IDLE, counter t=0, start_ready=1, op_rst=1, spk_out=0, res_valid=0, res_time=0, res_spike=0, busy=0. Asserting grst mid-run cancels the run immediately; no result is produced.
- States are IDLE, RUN and DONE.
- IDLE:
  - start_ready=1, op_rst=1, busy=0.
  - A request is accepted at an edge with start_valid=1. At that edge, latch start_times and start_mask, set t=0, clear the capture flag, and go to RUN.
  - A start_time value >= G is latched as a no-spike input.
- RUN:
  - op_rst=0, busy=1, start_ready=0. Lasts exactly G cycles, t=0..G-1.
  - spk_out[i]=1 during cycles where mask[i]=1 and time[i] <= t < time[i]+P.
  - Pulses are truncated at t=G-1: no wrap into the next gamma cycle. spk_out is glitch-free and registered.
  - Capture: at each edge in RUN, if op_y=1 and nothing has been captured yet, set res_time=t and res_spike=1. Only the first high is recorded; later highs and drops are ignored.
  - At the edge with t=G-1, the capture rule still applies, then the state goes to DONE.
  - If nothing was captured: res_spike=0 and res_time=G-1.
- DONE:
  - res_valid=1, op_rst=1, spk_out=0, start_ready=0.
  - res_time and res_spike stay stable until an edge with res_ready=1, then go to IDLE with res_valid=0.
  - start_valid is ignored in DONE; there is no request/result overlap.
- Latency: accept edge E, first RUN cycle follows E, res_valid rises at E+G edges. Minimum issue interval is G+2 cycles with res_ready tied high.
- abort (sampled in RUN only): next edge goes to IDLE with spk_out=0 and op_rst=1. No res_valid is produced; res_time/res_spike keep their old values. If abort coincides with the t=G-1 edge, abort wins. abort in IDLE or DONE has no effect.
- Simultaneous events:
  - op_y=1 at t=0 gives res_time=0.
  - time[i]=0 drives the pulse from the first RUN cycle.
  - Equal times on several inputs give identical pulses.

Test Plan (N_IN=2, G=16, P=8):
1. Accept times {a=2, b=4}, mask=11; bench raises op_y at t=4 → spk_out[0] high t=2..9, spk_out[1] high t=4..11; res_valid 16 cycles after accept; res_time=4, res_spike=1.
2. mask=00, op_y held 0 → spk_out stays 0, op_rst=0 for 16 cycles; res_spike=0, res_time=15.
3. times {a=12, b=0}, mask=11 → spk_out[0] high t=12..15 only and 0 in DONE; spk_out[1] high t=0..7; op_y high at t=0 and t=9 → res_time=0.
4. Result backpressure: res_ready=0 for 5 cycles → res_valid/res_time/res_spike stable, start_ready=0, start_valid ignored. After the res_ready handshake: IDLE, start_ready=1, next request accepted.
5. abort asserted at t=5 → next cycle IDLE, spk_out=0, op_rst=1, no res_valid; the following request completes normally with correct res_time.
6. grst pulsed mid-RUN (t=7, between edges) → all outputs reach reset values without waiting for an aclk edge; no res_valid after release; a new request after release behaves as in scenario 1.
